// File: rtl/shift_sequencer.sv
// Multi-cycle 16-bit shifter for the execute stage. Each shift is split into
// steps of at most 2**STEP_W-1 bit positions, one step per clock.

module shift_stage #(
  parameter int WIDTH = 16,
  parameter int DIST  = 1
) (
  input  logic             en,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_comb begin
    q = d;
    if (en) begin
      case (op)
        2'b00:   q = {d[WIDTH-DIST-1:0], {DIST{1'b0}}};
        2'b01:   q = {{DIST{1'b0}}, d[WIDTH-1:DIST]};
        2'b10:   q = {{DIST{d[WIDTH-1]}}, d[WIDTH-1:DIST]};
        default: q = {d[WIDTH-DIST-1:0], d[WIDTH-1:WIDTH-DIST]};
      endcase
    end
  end
endmodule

module shift_sequencer #(
  parameter int WIDTH  = 16,
  parameter int STEP_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [3:0]       in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             busy
);
  localparam int AMT_W = 4;
  localparam logic [AMT_W-1:0] STEP_MAX = AMT_W'(2**STEP_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                   state;
  logic [WIDTH-1:0]         work;
  logic [AMT_W-1:0]         rem;
  logic [1:0]               op;
  logic [STEP_W-1:0]        step;
  logic [AMT_W-1:0]         rem_nxt;
  logic [STEP_W:0][WIDTH-1:0] stg;

  assign step    = (rem > STEP_MAX) ? STEP_MAX[STEP_W-1:0] : rem[STEP_W-1:0];
  assign rem_nxt = rem - {{(AMT_W-STEP_W){1'b0}}, step};

  // Log shifter: stage i moves by 2**i when step bit i is set. Every stage
  // applies the same op, so SRA/ROL compose exactly across stages and cycles.
  assign stg[0] = work;
  generate
    for (genvar i = 0; i < STEP_W; i++) begin : g_stage
      shift_stage #(.WIDTH(WIDTH), .DIST(1 << i)) u_stage (
        .en (step[i]),
        .op (op),
        .d  (stg[i]),
        .q  (stg[i+1])
      );
    end
  endgenerate

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      work      <= '0;
      rem       <= '0;
      op        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work <= in_data;
            rem  <= in_amt;
            op   <= in_op;
            if (in_amt == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_data  <= in_data;
              out_zero  <= (in_data == '0);
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work <= stg[STEP_W];
          rem  <= rem_nxt;
          // Result registers load on the final step so out_valid rises on DONE entry.
          if (rem_nxt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_data  <= stg[STEP_W];
            out_zero  <= (stg[STEP_W] == '0);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: expected results are queued at
// stimulus time and popped when the DUT presents a result.

module tb_shift_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [3:0]  in_amt = '0;
  logic [1:0]  in_op = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_zero;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] data;
    logic        zero;
    int          lat;
  } exp_t;

  exp_t sb[$];

  shift_sequencer #(.WIDTH(16), .STEP_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [1:0] op, input logic [15:0] d, input logic [3:0] amt);
    exp_t e;
    logic [31:0] dd;
    logic signed [15:0] sd;
    dd = {d, d} << amt;
    sd = d;
    case (op)
      2'd0:    e.data = d << amt;
      2'd1:    e.data = d >> amt;
      2'd2:    e.data = sd >>> amt;
      default: e.data = dd[31:16];
    endcase
    e.zero = (e.data == 16'h0);
    e.lat  = 1 + (int'(amt) + 6) / 7;
    return e;
  endfunction

  // Drives one accept; returns #1 after the accept edge with inputs scrambled.
  task automatic send(input logic [1:0] op, input logic [15:0] d, input logic [3:0] amt);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (in_ready !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL send_wait: in_ready=%b required 1", in_ready);
    end
    in_op = op; in_data = d; in_amt = amt; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    in_amt   = 4'($urandom);
    in_op    = 2'($urandom);
  endtask

  // Counts cycles from the accept edge to out_valid; lat=-1 on timeout.
  task automatic collect(output logic [15:0] d, output logic z, output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    if (out_valid !== 1'b1) lat = -1;
    d = out_data;
    z = out_zero;
  endtask

  task automatic test_reset;
    in_valid = 1'b1; in_data = 16'hFFFF; in_amt = 4'd3;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({out_valid, out_data, out_zero, busy, in_ready} !== {1'b0, 16'h0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: ov=%b od=%h oz=%b busy=%b ir=%b required 0 0000 0 0 1",
               out_valid, out_data, out_zero, busy, in_ready);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b ir=%b required 0 1", busy, in_ready);
    end
  endtask

  task automatic test_ops;
    logic [1:0]  t_op [9] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0, 2'd3, 2'd2};
    logic [15:0] t_d  [9] = '{16'h00D5, 16'h00D5, 16'h8000, 16'h8000, 16'h4000, 16'hD501, 16'h0100, 16'h8001, 16'h7FFF};
    logic [3:0]  t_a  [9] = '{4'd0, 4'd4, 4'd15, 4'd15, 4'd14, 4'd9, 4'd8, 4'd1, 4'd7};
    logic [15:0] t_x  [9] = '{16'h00D5, 16'h0D50, 16'h0001, 16'hFFFF, 16'h0001, 16'h03AA, 16'h0000, 16'h0003, 16'h00FF};
    for (int i = 0; i < 29; i++) begin
      logic [1:0] op; logic [15:0] d; logic [3:0] a;
      logic [15:0] rd; logic rz; int lat; exp_t e;
      if (i < 9) begin
        op = t_op[i]; d = t_d[i]; a = t_a[i];
      end else begin
        op = 2'($urandom); d = 16'($urandom); a = 4'($urandom);
        if (i % 5 == 0) d = 16'h0;
      end
      e = model(op, d, a);
      if (i < 9) e.data = t_x[i];
      sb.push_back(e);
      send(op, d, a);
      collect(rd, rz, lat);
      e = sb.pop_front();
      n_tests++;
      if (lat != e.lat) begin
        n_fail++;
        $display("FAIL op%0d_latency: got %0d required %0d (op=%0d d=%h amt=%0d)", i, lat, e.lat, op, d, a);
      end
      n_tests++;
      if (rd !== e.data || rz !== e.zero) begin
        n_fail++;
        $display("FAIL op%0d_result: got %h/z%b required %h/z%b (op=%0d d=%h amt=%0d)",
                 i, rd, rz, e.data, e.zero, op, d, a);
      end
      n_tests++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL op%0d_done_flags: ir=%b busy=%b required 0 1", i, in_ready, busy);
      end
      @(posedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL op%0d_handoff: ov=%b ir=%b busy=%b required 0 1 0", i, out_valid, in_ready, busy);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] rd; logic rz; int lat; exp_t e;
    out_ready = 1'b0;
    sb.push_back(model(2'd0, 16'h0001, 4'd15));
    send(2'd0, 16'h0001, 4'd15);
    collect(rd, rz, lat);
    e = sb.pop_front();
    n_tests++;
    if (lat != 4 || rd !== e.data) begin
      n_fail++;
      $display("FAIL bp_result: lat=%0d data=%h required 4 %h", lat, rd, e.data);
    end
    in_valid = 1'b1; in_data = 16'hFFFF; in_amt = 4'd0;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 16'h8000 || out_zero !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: ov=%b od=%h oz=%b ir=%b required 1 8000 0 0",
                 k, out_valid, out_data, out_zero, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: ov=%b ir=%b required 0 1", out_valid, in_ready);
    end
    sb.push_back(model(2'd3, 16'h8001, 4'd1));
    send(2'd3, 16'h8001, 4'd1);
    collect(rd, rz, lat);
    e = sb.pop_front();
    n_tests++;
    if (lat != 2 || rd !== 16'h0003 || rd !== e.data) begin
      n_fail++;
      $display("FAIL bp_next_op: lat=%0d data=%h required 2 0003", lat, rd);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop;
    logic [15:0] rd; logic rz; int lat; int seen;
    // Abandon during SHIFT.
    send(2'd1, 16'h8000, 4'd15);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_tests++;
    if ({out_valid, out_data, out_zero, busy, in_ready} !== {1'b0, 16'h0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_shift: ov=%b od=%h oz=%b busy=%b ir=%b required 0 0000 0 0 1",
               out_valid, out_data, out_zero, busy, in_ready);
    end
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (out_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL rst_no_pulse: out_valid cycles=%0d required 0", seen);
    end
    // Abandon while holding a result in DONE.
    out_ready = 1'b0;
    send(2'd0, 16'h1234, 4'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_done: ov=%b od=%h ir=%b required 0 0000 1", out_valid, out_data, in_ready);
    end
    sb.push_back(model(2'd3, 16'h8001, 4'd1));
    send(2'd3, 16'h8001, 4'd1);
    collect(rd, rz, lat);
    begin
      exp_t e;
      e = sb.pop_front();
      n_tests++;
      if (lat != e.lat || rd !== 16'h0003 || rz !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_followup: lat=%0d data=%h z=%b required %0d 0003 0", lat, rd, rz, e.lat);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [1:0]  b_op [5] = '{2'd0, 2'd2, 2'd3, 2'd1, 2'd0};
    logic [15:0] b_d  [5] = '{16'h00D5, 16'h8000, 16'hD501, 16'hFFFF, 16'h0001};
    logic [3:0]  b_a  [5] = '{4'd0, 4'd15, 4'd9, 4'd3, 4'd14};
    int acc [5];
    fork
      begin
        int t = 0;
        for (int i = 0; i < 5; i++) begin
          int n = 0;
          in_op = b_op[i]; in_data = b_d[i]; in_amt = b_a[i]; in_valid = 1'b1;
          sb.push_back(model(b_op[i], b_d[i], b_a[i]));
          while (in_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1; t++; n++;
          end
          @(posedge clk);
          acc[i] = t;
          t++;
          #1;
        end
        in_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 5; k++) begin
          int n = 0;
          exp_t e;
          do begin
            @(negedge clk); n++;
          end while (out_valid !== 1'b1 && n < 40);
          e = sb.pop_front();
          n_tests++;
          if (out_valid !== 1'b1 || out_data !== e.data || out_zero !== e.zero) begin
            n_fail++;
            $display("FAIL b2b_result%0d: ov=%b od=%h oz=%b required 1 %h %b",
                     k, out_valid, out_data, out_zero, e.data, e.zero);
          end
        end
      end
    join
    for (int i = 1; i < 5; i++) begin
      int want;
      want = 2 + (int'(b_a[i-1]) + 6) / 7;
      n_tests++;
      if (acc[i] - acc[i-1] != want) begin
        n_fail++;
        $display("FAIL b2b_interval%0d: got %0d cycles required %0d", i, acc[i] - acc[i-1], want);
      end
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    test_reset();
    test_ops();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
